popcount_window_accumulator: RTL and testbench

//  Downstream consumer of the 4-input signal counter (3-bit count, 0..4 ones per sample).

---
 rtl/popcount_window_accumulator.sv | 125 ++++++++++++
 tb/tb_popcount_window_accumulator.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_window_accumulator.sv
// Sums WINDOW accepted popcount samples (0..4 each) into a saturating total; optional peak tracking via COUNT_PEAK_EN.
// Latency: out_valid registered on the edge accepting the WINDOW-th sample, visible the next cycle.
// Backpressure: in_ready drops while a total is held; the total is held until out_ready, then the next window starts.
module popcount_window_accumulator #(
  parameter int WINDOW = 8,   // accepted samples per window, 1..255
  parameter int SUM_W  = 6    // total width, assumed >= 3 so the SUM_W+1 accumulator absorbs one +4 step
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_count,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_sat,
  input  logic             out_ready
`ifdef COUNT_PEAK_EN
  ,
  output logic [2:0]       out_peak
`endif
);

  localparam logic [SUM_W:0] SUM_MAX  = {1'b0, {SUM_W{1'b1}}};
  localparam logic [7:0]     WIN_LAST = 8'(WINDOW);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t         state_q;
  logic [SUM_W:0] sum_q, sum_d;
  logic           sat_q, sat_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [2:0]     count_clamped;
  logic           accept;
  logic [SUM_W:0] raw_sum;
`ifdef COUNT_PEAK_EN
  logic [2:0]     peak_q, peak_d;
`endif

  // Clamp illegal counts and form the saturating next total for an accepted sample.
  // sum_q/sat_q/cnt_q are always zero in IDLE, so the same update covers the first sample.
  always_comb begin
    count_clamped = (in_count > 3'd4) ? 3'd4 : in_count;
    accept        = in_valid & in_ready_q;
    raw_sum       = sum_q + {{(SUM_W-2){1'b0}}, count_clamped};
    cnt_d         = cnt_q + 8'd1;
    if (raw_sum > SUM_MAX) begin
      sum_d = SUM_MAX;
      sat_d = 1'b1;
    end else begin
      sum_d = raw_sum;
      sat_d = sat_q;
    end
  end

`ifdef COUNT_PEAK_EN
  // Running maximum of clamped counts within the window.
  always_comb begin
    peak_d = (count_clamped > peak_q) ? count_clamped : peak_q;
  end
`endif

  // Window FSM: accumulate until WINDOW accepts, then hold the total until it is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef COUNT_PEAK_EN
      peak_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            sum_q  <= sum_d;
            sat_q  <= sat_d;
            cnt_q  <= cnt_d;
`ifdef COUNT_PEAK_EN
            peak_q <= peak_d;
`endif
            if (cnt_d == WIN_LAST) begin
              state_q     <= S_HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef COUNT_PEAK_EN
            peak_q      <= '0;
`endif
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q[SUM_W-1:0];
  assign out_sat   = sat_q;
`ifdef COUNT_PEAK_EN
  assign out_peak  = peak_q;
`endif

endmodule

// File: tb/tb_popcount_window_accumulator.sv
// Bench for popcount_window_accumulator: three instances (WINDOW=8/SUM_W=6, WINDOW=8/SUM_W=4, WINDOW=1/SUM_W=6)
// share one input stream; a window-level model (sample count, plain total, max) predicts every instance.
// Directed sequences, a WINDOW=1 vector table and a randomized run.
module tb_popcount_window_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_count;
  logic       out_ready;

  logic       rdy_a, rdy_b, rdy_c;
  logic       ov_a, ov_b, ov_c;
  logic [5:0] sum_a;
  logic [3:0] sum_b;
  logic [5:0] sum_c;
  logic       sat_a, sat_b, sat_c;
`ifdef COUNT_PEAK_EN
  logic [2:0] pk_a, pk_b, pk_c;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  popcount_window_accumulator #(.WINDOW(8), .SUM_W(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .in_ready(rdy_a),
    .out_valid(ov_a), .out_sum(sum_a), .out_sat(sat_a), .out_ready(out_ready)
`ifdef COUNT_PEAK_EN
    , .out_peak(pk_a)
`endif
  );
  popcount_window_accumulator #(.WINDOW(8), .SUM_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .in_ready(rdy_b),
    .out_valid(ov_b), .out_sum(sum_b), .out_sat(sat_b), .out_ready(out_ready)
`ifdef COUNT_PEAK_EN
    , .out_peak(pk_b)
`endif
  );
  popcount_window_accumulator #(.WINDOW(1), .SUM_W(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .in_ready(rdy_c),
    .out_valid(ov_c), .out_sum(sum_c), .out_sat(sat_c), .out_ready(out_ready)
`ifdef COUNT_PEAK_EN
    , .out_peak(pk_c)
`endif
  );

  // Reference model, one entry per instance.
  int m_win[3]  = '{8, 8, 1};
  int m_max[3]  = '{63, 15, 63};
  int m_n[3];
  int m_tot[3];
  int m_pk[3];
  bit m_hold[3];

  int d_rdy[3], d_ov[3], d_sum[3], d_sat[3], d_pk[3];
  string nm[3] = '{"A", "B", "C"};

  always_comb begin
    d_rdy = '{int'(rdy_a), int'(rdy_b), int'(rdy_c)};
    d_ov  = '{int'(ov_a), int'(ov_b), int'(ov_c)};
    d_sum = '{int'(sum_a), int'(sum_b), int'(sum_c)};
    d_sat = '{int'(sat_a), int'(sat_b), int'(sat_c)};
`ifdef COUNT_PEAK_EN
    d_pk  = '{int'(pk_a), int'(pk_b), int'(pk_c)};
`else
    d_pk  = '{0, 0, 0};
`endif
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_n[i] = 0; m_tot[i] = 0; m_pk[i] = 0; m_hold[i] = 0;
    end
  endtask

  // Expected outputs: sum/sat/peak are checked while a total is held or the window is empty.
  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      chk({nm[i], ".in_ready"}, d_rdy[i], m_hold[i] ? 0 : 1);
      chk({nm[i], ".out_valid"}, d_ov[i], m_hold[i] ? 1 : 0);
      if (m_hold[i] || m_n[i] == 0) begin
        chk({nm[i], ".out_sum"}, d_sum[i], (m_tot[i] > m_max[i]) ? m_max[i] : m_tot[i]);
        chk({nm[i], ".out_sat"}, d_sat[i], (m_tot[i] > m_max[i]) ? 1 : 0);
`ifdef COUNT_PEAK_EN
        chk({nm[i], ".out_peak"}, d_pk[i], m_pk[i]);
`endif
      end
    end
  endtask

  task automatic model_step();
    int c;
    c = (in_count > 3'd4) ? 4 : int'(in_count);
    for (int i = 0; i < 3; i++) begin
      if (m_hold[i]) begin
        if (out_ready) begin
          m_hold[i] = 0; m_n[i] = 0; m_tot[i] = 0; m_pk[i] = 0;
        end
      end else if (in_valid) begin
        m_n[i]++;
        m_tot[i] += c;
        if (c > m_pk[i]) m_pk[i] = c;
        if (m_n[i] == m_win[i]) m_hold[i] = 1;
      end
    end
  endtask

  // One clock: drive, compare pre-edge outputs at negedge, advance model at posedge.
  task automatic cycle(input bit v, input int c, input bit r);
    in_valid  = v;
    in_count  = 3'(c);
    out_ready = r;
    @(negedge clk);
    check_models();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst.A.out_valid", int'(ov_a), 0);
    chk("rst.A.out_sum", int'(sum_a), 0);
    chk("rst.A.out_sat", int'(sat_a), 0);
    chk("rst.B.out_valid", int'(ov_b), 0);
    chk("rst.C.out_valid", int'(ov_c), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.A.in_ready", int'(rdy_a), 1);
  endtask

  typedef struct {
    bit v; int c; bit r;
    int e_ov; int e_sum; int e_rdy;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 3, 0, 1, 3, 0};
    tbl[1] = '{1, 2, 0, 1, 3, 0};
    tbl[2] = '{1, 2, 1, 0, 0, 1};
    tbl[3] = '{1, 7, 0, 1, 4, 0};
    tbl[4] = '{0, 0, 1, 0, 0, 1};
    tbl[5] = '{0, 1, 0, 0, 0, 1};
    tbl[6] = '{1, 0, 1, 1, 0, 0};
    tbl[7] = '{1, 1, 1, 0, 0, 1};
    tbl[8] = '{1, 1, 1, 1, 1, 0};
    tbl[9] = '{0, 0, 1, 0, 0, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    #3;
    chk("init.A.out_valid", int'(ov_a), 0);
    chk("init.A.out_sum", int'(sum_a), 0);
    model_reset();
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // WINDOW=1 instance: every accept gives out_valid next cycle.
    for (int k = 0; k < 10; k++) begin
      cycle(tbl[k].v, tbl[k].c, tbl[k].r);
      chk($sformatf("tbl%0d.C.out_valid", k), int'(ov_c), tbl[k].e_ov);
      chk($sformatf("tbl%0d.C.out_sum", k), int'(sum_c), tbl[k].e_sum);
      chk($sformatf("tbl%0d.C.in_ready", k), int'(rdy_c), tbl[k].e_rdy);
    end

    do_reset();

    // Eight back-to-back 4s.
    for (int k = 0; k < 8; k++) begin
      cycle(1, 4, 1);
      if (k == 6) chk("t1.A.valid_early", int'(ov_a), 0);
    end
    chk("t1.A.out_valid", int'(ov_a), 1);
    chk("t1.A.out_sum", int'(sum_a), 32);
    chk("t1.A.out_sat", int'(sat_a), 0);
    chk("t1.A.in_ready", int'(rdy_a), 0);
    chk("t3.B.out_sum", int'(sum_b), 15);
    chk("t3.B.out_sat", int'(sat_b), 1);
    cycle(0, 0, 1);
    chk("t1.A.in_ready_back", int'(rdy_a), 1);
    chk("t1.A.valid_drop", int'(ov_a), 0);
    chk("t3.B.sum_drain", int'(sum_b), 0);
    chk("t3.B.sat_drain", int'(sat_b), 0);

    // Counts with idle gaps.
    for (int k = 0; k < 8; k++) begin
      cycle(1, k % 5, 0);
      if (k < 7) begin
        cycle(0, 0, 0);
        cycle(0, 0, 0);
      end
    end
    chk("t2.A.out_valid", int'(ov_a), 1);
    chk("t2.A.out_sum", int'(sum_a), 13);
`ifdef COUNT_PEAK_EN
    chk("t2.A.out_peak", int'(pk_a), 4);
`endif

    // Stalled in HOLD with a sample waiting upstream.
    for (int k = 0; k < 5; k++) begin
      cycle(1, 3, 0);
      chk("t4.A.in_ready", int'(rdy_a), 0);
      chk("t4.A.out_sum", int'(sum_a), 13);
    end
    cycle(1, 3, 1);
    chk("t4.A.drained", int'(ov_a), 0);
    cycle(1, 3, 0);
    for (int k = 0; k < 7; k++) cycle(1, 1, 0);
    chk("t4.A.next_sum", int'(sum_a), 10);
    chk("t4.A.next_valid", int'(ov_a), 1);
    cycle(0, 0, 1);

    // Reset mid-window discards the partial total.
    for (int k = 0; k < 5; k++) cycle(1, 1, 0);
    do_reset();
    for (int k = 0; k < 8; k++) cycle(1, 1, 0);
    chk("t5.A.out_sum", int'(sum_a), 8);
    chk("t5.A.out_valid", int'(ov_a), 1);
    cycle(0, 0, 1);

    // Illegal counts clamp to 4.
    for (int k = 0; k < 8; k++) cycle(1, 7, 1);
    chk("t6.A.out_sum", int'(sum_a), 32);
    chk("t6.A.out_valid", int'(ov_a), 1);
    cycle(0, 0, 1);
    chk("t6.A.sum_drain", int'(sum_a), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      cycle($urandom_range(9, 0) < 7, $urandom_range(7, 0), $urandom_range(1, 0) == 1);
    end
    @(negedge clk);
    check_models();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
